// File: rtl/irq_pkg.sv
// rtl/irq_pkg.sv - shared types and sizes for the prioritised interrupt controller
package irq_pkg;

    localparam int NUM_IRQ = 8;
    localparam int VEC_W   = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_e;

endpackage

// File: rtl/irq_prio_ctrl8_if.sv
// rtl/irq_prio_ctrl8_if.sv - CPU/peripheral side signal bundle of the interrupt controller
interface irq_prio_ctrl8_if
    import irq_pkg::*;
;
    logic [NUM_IRQ-1:0] irq;
    logic               int_ack;
    logic               eoi;
    logic               mask_we;
    logic [NUM_IRQ-1:0] mask_wdata;
    logic               int_req;
    logic [VEC_W-1:0]   int_vec;
    logic [NUM_IRQ-1:0] pending;
    logic [NUM_IRQ-1:0] in_service;
    logic [NUM_IRQ-1:0] mask;

    // Controller side
    modport slave (
        input  irq, int_ack, eoi, mask_we, mask_wdata,
        output int_req, int_vec, pending, in_service, mask
    );

    // CPU / stimulus side
    modport master (
        output irq, int_ack, eoi, mask_we, mask_wdata,
        input  int_req, int_vec, pending, in_service, mask
    );

endinterface

// File: rtl/prio_enc8.sv
// rtl/prio_enc8.sv - 8-bit priority encoder, bit 7 highest
module prio_enc8 (
    input  logic [7:0] req,
    output logic       valid,
    output logic [2:0] idx
);

    // Scan upward so the highest set bit is the last one to write idx
    always_comb begin
        valid = 1'b0;
        idx   = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (req[i]) begin
                valid = 1'b1;
                idx   = 3'(i);
            end
        end
    end

endmodule

// File: rtl/irq_prio_ctrl8.sv
// rtl/irq_prio_ctrl8.sv - eight-source prioritised interrupt controller with nesting
module irq_prio_ctrl8
    import irq_pkg::*;
#(
    parameter logic [NUM_IRQ-1:0] RESET_MASK = 8'hFF
) (
    input  logic             clk,
    input  logic             rst,
    irq_prio_ctrl8_if.slave  bus
);

    state_e             state_q, state_d;
    logic [NUM_IRQ-1:0] irq_q, irq_d;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [NUM_IRQ-1:0] in_service_q, in_service_d;
    logic [NUM_IRQ-1:0] mask_q, mask_d;
    logic               int_req_q, int_req_d;
    logic [VEC_W-1:0]   int_vec_q, int_vec_d;

    logic [NUM_IRQ-1:0] cand;
    logic               c_valid, s_valid;
    logic [VEC_W-1:0]   c_idx, s_idx;
    logic               eligible;
    logic [NUM_IRQ-1:0] edge_det;
    logic [NUM_IRQ-1:0] ack_bits;
    logic [NUM_IRQ-1:0] isr_after_eoi;

    assign cand     = pending_q & ~mask_q;
    assign edge_det = bus.irq & ~irq_q;

    prio_enc8 u_cand_enc (
        .req   (cand),
        .valid (c_valid),
        .idx   (c_idx)
    );

    prio_enc8 u_isr_enc (
        .req   (in_service_q),
        .valid (s_valid),
        .idx   (s_idx)
    );

    // Only a strictly higher priority than the current in-service level may nest
    assign eligible = c_valid && (!s_valid || (c_idx > s_idx));

    // Next-state: request FSM, pending/in-service bookkeeping and mask register
    always_comb begin
        state_d       = state_q;
        irq_d         = bus.irq;
        mask_d        = mask_q;
        int_req_d     = int_req_q;
        int_vec_d     = int_vec_q;
        ack_bits      = '0;
        isr_after_eoi = in_service_q;

        // EOI acts on the old in-service value; the ack bit is ORed in afterwards
        if (bus.eoi && s_valid) begin
            isr_after_eoi[s_idx] = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                int_req_d = 1'b0;
                if (eligible) begin
                    state_d   = ST_REQ;
                    int_vec_d = c_idx;
                    int_req_d = 1'b1;
                end
            end
            ST_REQ: begin
                int_req_d = 1'b1;
                if (bus.int_ack) begin
                    ack_bits  = {{(NUM_IRQ-1){1'b0}}, 1'b1} << int_vec_q;
                    state_d   = ST_IDLE;
                    int_req_d = 1'b0;
                end else if (!(pending_q[int_vec_q] & ~mask_q[int_vec_q])) begin
                    // Source masked while waiting for the CPU: withdraw the request
                    state_d   = ST_IDLE;
                    int_req_d = 1'b0;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                int_req_d = 1'b0;
            end
        endcase

        // A new edge in the ack cycle wins over the ack clear
        pending_d    = (pending_q & ~ack_bits) | edge_det;
        in_service_d = isr_after_eoi | ack_bits;

        if (bus.mask_we) begin
            mask_d = bus.mask_wdata;
        end
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            irq_q        <= '0;
            pending_q    <= '0;
            in_service_q <= '0;
            mask_q       <= RESET_MASK;
            int_req_q    <= 1'b0;
            int_vec_q    <= '0;
        end else begin
            state_q      <= state_d;
            irq_q        <= irq_d;
            pending_q    <= pending_d;
            in_service_q <= in_service_d;
            mask_q       <= mask_d;
            int_req_q    <= int_req_d;
            int_vec_q    <= int_vec_d;
        end
    end

    assign bus.int_req    = int_req_q;
    assign bus.int_vec    = int_vec_q;
    assign bus.pending    = pending_q;
    assign bus.in_service = in_service_q;
    assign bus.mask       = mask_q;

endmodule
